// File: rtl/opendap_ap_mux.sv
// AP interconnect between the SW-DP AP port and N_APS downstream Access Ports:
// APSEL decode, registered completion, RAZ/WI for unimplemented APs, abort fan-out, watchdog.
module opendap_ap_mux #(
    parameter int N_APS   = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                  swclk,
    input  logic                  rst,
    input  logic [7:0]            up_sel,
    input  logic [5:0]            up_addr,
    input  logic [31:0]           up_wdata,
    input  logic                  up_wen,
    input  logic                  up_ren,
    input  logic                  up_abort,
    output logic [31:0]           up_rdata,
    output logic                  up_rdy,
    output logic                  up_err,
    output logic                  timeout_evt,
    output logic [5:0]            dn_addr,
    output logic [31:0]           dn_wdata,
    output logic [N_APS-1:0]      dn_wen,
    output logic [N_APS-1:0]      dn_ren,
    output logic [N_APS-1:0]      dn_abort,
    input  logic [32*N_APS-1:0]   dn_rdata,
    input  logic [N_APS-1:0]      dn_rdy,
    input  logic [N_APS-1:0]      dn_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int             CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [8:0]     N_APS_W  = 9'(N_APS);
    localparam logic           WD_EN    = (TIMEOUT != 0);

    state_t             state_r;
    state_t             state_s;
    logic [7:0]         active_r;
    logic [31:0]        rdata_r;
    logic               err_r;
    logic               timeout_evt_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [N_APS-1:0]   sel_hit_s;
    logic [N_APS-1:0]   act_hit_s;
    logic [31:0]        act_rdata_s;
    logic               act_rdy_s;
    logic               act_err_s;
    logic               idle_s;
    logic               busy_s;
    logic               strobe_s;
    logic               sel_valid_s;
    logic               accept_s;
    logic               raz_s;
    logic               complete_s;
    logic               abort_busy_s;
    logic               wd_fire_s;

    // Per-AP decode of the upstream select and of the AP owning the transfer
    always_comb begin
        sel_hit_s   = '0;
        act_hit_s   = '0;
        act_rdata_s = 32'd0;
        for (int i = 0; i < N_APS; i++) begin
            sel_hit_s[i] = (up_sel == 8'(i));
            act_hit_s[i] = (active_r == 8'(i));
            act_rdata_s  = act_rdata_s | (dn_rdata[32*i +: 32] & {32{act_hit_s[i]}});
        end
    end

    assign act_rdy_s = |(dn_rdy & act_hit_s);
    assign act_err_s = |(dn_err & act_hit_s);

    // Transfer control terms; abort outranks completion, which outranks the watchdog
    always_comb begin
        idle_s       = (state_r == ST_IDLE);
        busy_s       = (state_r == ST_BUSY);
        strobe_s     = up_wen | up_ren;
        sel_valid_s  = ({1'b0, up_sel} < N_APS_W);
        accept_s     = idle_s & strobe_s & ~up_abort & sel_valid_s;
        raz_s        = idle_s & strobe_s & ~up_abort & ~sel_valid_s;
        abort_busy_s = busy_s & up_abort;
        complete_s   = busy_s & ~up_abort & act_rdy_s;
        wd_fire_s    = busy_s & ~up_abort & ~act_rdy_s & WD_EN & (cnt_r == CNT_LAST);
    end

    // State register
    always_ff @(posedge swclk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (abort_busy_s || complete_s || wd_fire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output logic: downstream strobes are combinational from the upstream request
    always_comb begin
        up_rdy   = idle_s;
        dn_addr  = up_addr;
        dn_wdata = up_wdata;
        dn_wen   = (accept_s && up_wen) ? sel_hit_s : '0;
        dn_ren   = (accept_s && up_ren) ? sel_hit_s : '0;
        if (up_abort) begin
            dn_abort = {N_APS{1'b1}};
        end else if (wd_fire_s) begin
            dn_abort = act_hit_s;
        end else begin
            dn_abort = '0;
        end
    end

    // Completion datapath, watchdog counter and single-cycle status pulses
    always_ff @(posedge swclk) begin
        if (rst) begin
            active_r      <= 8'd0;
            rdata_r       <= 32'd0;
            err_r         <= 1'b0;
            timeout_evt_r <= 1'b0;
            cnt_r         <= '0;
        end else begin
            err_r         <= 1'b0;
            timeout_evt_r <= 1'b0;
            if (accept_s) begin
                active_r <= up_sel;
                cnt_r    <= '0;
            end else if (raz_s) begin
                rdata_r <= 32'd0;
            end else if (abort_busy_s) begin
                cnt_r <= cnt_r;
            end else if (complete_s) begin
                rdata_r <= act_rdata_s;
                err_r   <= act_err_s;
            end else if (wd_fire_s) begin
                rdata_r       <= 32'd0;
                err_r         <= 1'b1;
                timeout_evt_r <= 1'b1;
            end else if (busy_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign up_rdata    = rdata_r;
    assign up_err      = err_r;
    assign timeout_evt = timeout_evt_r;

endmodule

// File: tb/tb_opendap_ap_mux.sv
// Scoreboard bench for opendap_ap_mux (N_APS=4, TIMEOUT=8): expected completions are
// queued when an access is launched and compared when up_rdy returns.
module tb_opendap_ap_mux;

    localparam int N  = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tevt;
    } exp_t;

    logic              swclk = 1'b0;
    logic              rst;
    logic [7:0]        up_sel;
    logic [5:0]        up_addr;
    logic [31:0]       up_wdata;
    logic              up_wen;
    logic              up_ren;
    logic              up_abort;
    logic [31:0]       up_rdata;
    logic              up_rdy;
    logic              up_err;
    logic              timeout_evt;
    logic [5:0]        dn_addr;
    logic [31:0]       dn_wdata;
    logic [N-1:0]      dn_wen;
    logic [N-1:0]      dn_ren;
    logic [N-1:0]      dn_abort;
    logic [32*N-1:0]   dn_rdata;
    logic [N-1:0]      dn_rdy;
    logic [N-1:0]      dn_err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    logic [31:0] last_rdata = 32'd0;

    opendap_ap_mux #(.N_APS(N), .TIMEOUT(TO)) dut (
        .swclk(swclk), .rst(rst),
        .up_sel(up_sel), .up_addr(up_addr), .up_wdata(up_wdata),
        .up_wen(up_wen), .up_ren(up_ren), .up_abort(up_abort),
        .up_rdata(up_rdata), .up_rdy(up_rdy), .up_err(up_err),
        .timeout_evt(timeout_evt),
        .dn_addr(dn_addr), .dn_wdata(dn_wdata),
        .dn_wen(dn_wen), .dn_ren(dn_ren), .dn_abort(dn_abort),
        .dn_rdata(dn_rdata), .dn_rdy(dn_rdy), .dn_err(dn_err)
    );

    always #5 swclk = ~swclk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge swclk);
        #1;
    endtask

    task automatic scramble_rdata();
        for (int i = 0; i < N; i++) dn_rdata[32*i +: 32] = $urandom;
    endtask

    // Compare the DUT's completion against the oldest queued expectation
    task automatic sb_compare(input string tag);
        exp_t e;
        check_eq({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq({tag, "_rdata"}, 64'(up_rdata), 64'(e.rdata));
            check_eq({tag, "_err"}, 64'(up_err), 64'(e.err));
            check_eq({tag, "_tevt"}, 64'(timeout_evt), 64'(e.tevt));
            last_rdata = e.rdata;
        end
    endtask

    // One upstream access; the bench plays the selected AP (wait cycles or hang)
    task automatic do_access(input string tag, input int sel, input bit wr, input int waits,
                             input logic [31:0] rd, input bit err, input bit hang);
        logic [N-1:0] onehot;
        int n_busy;
        exp_t e;
        onehot = (sel < N) ? N'(1 << sel) : '0;
        if (sel >= N)  e = '{rdata: 32'd0, err: 1'b0, tevt: 1'b0};
        else if (hang) e = '{rdata: 32'd0, err: 1'b1, tevt: 1'b1};
        else           e = '{rdata: rd, err: err, tevt: 1'b0};
        sb_q.push_back(e);

        up_sel   = 8'(sel);
        up_addr  = 6'($urandom);
        up_wdata = $urandom;
        up_wen   = wr;
        up_ren   = !wr;
        dn_rdy   = '1;
        scramble_rdata();
        @(negedge swclk);
        check_eq({tag, "_dn_wen"}, 64'(dn_wen), wr ? 64'(onehot) : 64'd0);
        check_eq({tag, "_dn_ren"}, 64'(dn_ren), wr ? 64'd0 : 64'(onehot));
        check_eq({tag, "_pass"}, {26'd0, dn_addr, dn_wdata}, {26'd0, up_addr, up_wdata});
        check_eq({tag, "_rdy0"}, 64'(up_rdy), 64'd1);
        tick();
        up_wen = 1'b0;
        up_ren = 1'b0;
        dn_rdy = '0;

        if (sel >= N) begin
            @(negedge swclk);
            check_eq({tag, "_raz_rdy"}, 64'(up_rdy), 64'd1);
            sb_compare(tag);
            tick();
            return;
        end

        n_busy = hang ? TO : waits + 1;
        for (int c = 1; c <= n_busy; c++) begin
            scramble_rdata();
            if (!hang && c == waits + 1) begin
                dn_rdy = onehot;
                dn_rdata[32*sel +: 32] = rd;
                dn_err = err ? onehot : '0;
            end else begin
                dn_rdy = ~onehot;
                dn_err = ~onehot;
            end
            @(negedge swclk);
            check_eq({tag, "_busy"}, 64'(up_rdy), 64'd0);
            check_eq({tag, "_dn_abort"}, 64'(dn_abort), (hang && c == TO) ? 64'(onehot) : 64'd0);
            tick();
            dn_rdy = '0;
            dn_err = '0;
        end
        @(negedge swclk);
        check_eq({tag, "_done_rdy"}, 64'(up_rdy), 64'd1);
        sb_compare(tag);
        tick();
        @(negedge swclk);
        check_eq({tag, "_pulse_err"}, 64'(up_err), 64'd0);
        check_eq({tag, "_pulse_tevt"}, 64'(timeout_evt), 64'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        up_sel = 8'd0; up_addr = 6'd0; up_wdata = 32'd0;
        up_wen = 1'b0; up_ren = 1'b0; up_abort = 1'b0;
        dn_rdata = '0; dn_rdy = '0; dn_err = '0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge swclk);
        check_eq("reset_rdy", 64'(up_rdy), 64'd1);
        check_eq("reset_rdata", 64'(up_rdata), 64'd0);
        check_eq("reset_err", 64'(up_err), 64'd0);
        check_eq("reset_tevt", 64'(timeout_evt), 64'd0);
        tick();

        do_access("rd_ap2", 2, 1'b0, 3, 32'h1234_5678, 1'b0, 1'b0);
        do_access("wr_ap3_err", 3, 1'b1, 1, 32'hCAFE_F00D, 1'b1, 1'b0);
        do_access("raz_sel10", 16, 1'b0, 0, 32'd0, 1'b0, 1'b0);
        do_access("rd_ap0", 0, 1'b0, 0, 32'hA5A5_0F0F, 1'b0, 1'b0);
        do_access("wdog_ap1", 1, 1'b0, 0, 32'd0, 1'b0, 1'b1);
        do_access("after_wdog", 0, 1'b0, 2, 32'h5555_AAAA, 1'b0, 1'b0);
        do_access("rdy_at_limit", 3, 1'b0, TO - 1, 32'h0000_0077, 1'b0, 1'b0);

        // Abort while busy, with the AP answering in the same cycle
        sb_q.push_back('{rdata: last_rdata, err: 1'b0, tevt: 1'b0});
        up_sel = 8'd2; up_ren = 1'b1;
        tick();
        up_sel = 8'd1; up_ren = 1'b1;
        @(negedge swclk);
        check_eq("busy_strobe_dn_ren", 64'(dn_ren), 64'd0);
        check_eq("busy_strobe_rdy", 64'(up_rdy), 64'd0);
        tick();
        up_ren = 1'b0;
        up_abort = 1'b1;
        dn_rdy = '1;
        dn_err = '1;
        scramble_rdata();
        @(negedge swclk);
        check_eq("abort_bcast", 64'(dn_abort), 64'hF);
        tick();
        up_abort = 1'b0; dn_rdy = '0; dn_err = '0;
        @(negedge swclk);
        check_eq("abort_rdy", 64'(up_rdy), 64'd1);
        sb_compare("abort");
        tick();

        // Abort in idle together with a strobe: strobe dropped, no transfer starts
        up_abort = 1'b1; up_ren = 1'b1; up_sel = 8'd0;
        @(negedge swclk);
        check_eq("idle_abort_dn_ren", 64'(dn_ren), 64'd0);
        check_eq("idle_abort_bcast", 64'(dn_abort), 64'hF);
        tick();
        up_abort = 1'b0; up_ren = 1'b0;
        @(negedge swclk);
        check_eq("idle_abort_rdy", 64'(up_rdy), 64'd1);
        tick();

        // Reset mid-transfer
        up_sel = 8'd1; up_ren = 1'b1;
        tick();
        up_ren = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge swclk);
        check_eq("rst_no_abort", 64'(dn_abort), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge swclk);
        check_eq("rst_mid_rdy", 64'(up_rdy), 64'd1);
        check_eq("rst_mid_rdata", 64'(up_rdata), 64'd0);
        check_eq("rst_mid_err", 64'(up_err), 64'd0);
        check_eq("rst_mid_tevt", 64'(timeout_evt), 64'd0);
        last_rdata = 32'd0;
        tick();
        do_access("post_rst", 1, 1'b0, 2, 32'h3141_5926, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/opendap_ap_mux.md
# opendap_ap_mux

Parametrised AP interconnect sitting between the SW-DP's AP interface and up to `N_APS` downstream Access Ports. It decodes the 8-bit APSEL and routes strobes to the selected AP. It registers the completion data and response so downstream APs need not hold `rdata`. It adds behaviour a single-AP bus lacks: RAZ/WI for unimplemented APSEL values, abort broadcast, and a per-transfer watchdog that forcibly completes a hung AP access with an error.

## Interface
Parameters:
- `N_APS`, 4, number of downstream APs (1..256); APSEL values `>= N_APS` are unimplemented.
- `TIMEOUT`, 0, watchdog limit in `swclk` cycles; 0 disables the watchdog.

Ports (one clock; reset is synchronous and active-high):
- `swclk`  in  1  sole clock.
- `rst`  in  1  synchronous active-high reset.
- `up_sel`  in  8  APSEL; valid only with `up_wen`/`up_ren`.
- `up_addr`  in  6  AP register address; valid only with a strobe.
- `up_wdata`  in  32  write data; valid only with `up_wen`.
- `up_wen`, `up_ren`  in  1  access strobes, single-cycle.
- `up_abort`  in  1  DAPABORT pulse.
- `up_rdata`  out  32  registered read data.
- `up_rdy`  out  1  high when idle.
- `up_err`  out  1  one-cycle error pulse, coincident with the first `up_rdy` cycle after completion.
- `timeout_evt`  out  1  one-cycle pulse when the watchdog fires.
- `dn_addr`  out  6  equals `up_addr` (combinational).
- `dn_wdata`  out  32  equals `up_wdata` (combinational).
- `dn_wen`, `dn_ren`, `dn_abort`  out  N_APS  per-AP strobes.
- `dn_rdata`  in  32*N_APS  AP i at bits [32i+31:32i].
- `dn_rdy`, `dn_err`  in  N_APS  per-AP ready and error.

## Operation
State: `busy`, `active` (8 b), `rdata_q` (32 b), `err_q` (1 b), `timeout_evt` register, watchdog counter `cnt`. Outputs: `up_rdy = !busy`, `up_rdata = rdata_q`, `up_err = err_q`.

IDLE (`busy=0`):
- Strobe with `up_sel < N_APS`:
  - `dn_wen[up_sel]`/`dn_ren[up_sel]` asserted combinationally in the same cycle.
  - Next edge: `busy<=1`, `active<=up_sel`, `cnt<=0`.
- Strobe with `up_sel >= N_APS`:
  - No downstream strobe.
  - Next edge: `rdata_q<=0`, `err_q<=0`, `busy` stays 0.
  - Result is RAZ/WI, completing with zero wait.
- Strobes are only legal while `up_rdy=1`. A strobe while busy is ignored: no downstream strobe, no state change.

BUSY:
- Completion: `dn_rdy[active]=1` → `rdata_q<=dn_rdata[active]`, `err_q<=dn_err[active]`, `busy<=0`.
- Otherwise: `cnt<=cnt+1`.
- If `TIMEOUT!=0` and `cnt==TIMEOUT-1` with no completion, the watchdog fires:
  - `dn_abort[active]` asserted that cycle.
  - Next edge: `busy<=0`, `rdata_q<=0`, `err_q<=1`, `timeout_evt<=1`.

Abort:
- `up_abort` drives `dn_abort` on all N_APS bits combinationally, in any state.
- If busy: next edge `busy<=0`, `err_q<=0`, `rdata_q` unchanged, no capture of that cycle's `dn_rdy`.
- If idle: no state change.

`err_q` and `timeout_evt` clear to 0 on every edge not setting them, so they are single-cycle pulses.

Priorities within one cycle:
- abort > completion > watchdog.
- abort > new strobe: the strobe is ignored and not forwarded.
- `dn_rdy` in the same cycle as the watchdog limit counts as completion; the watchdog does not fire.

## Timing
- Reset (`rst`=1 at an edge):
  - `busy=0`, `active=0`, `rdata_q=0`, `err_q=0`, `timeout_evt=0`, `cnt=0`.
  - `up_rdy=1` from the first cycle after reset.
  - Reset mid-transfer drops the transfer silently; no `dn_abort` is issued.
- Downstream strobes and address/data: zero latency (combinational from upstream).
- Minimum access latency:
  - Strobe in cycle 0; `up_rdy=0` in cycle 1.
  - If `dn_rdy` is high in cycle 1, completion is captured at the end of cycle 1.
  - `up_rdy=1` with valid `up_rdata`/`up_err` in cycle 2.
  - Each extra downstream wait cycle adds one cycle.
- `dn_rdy[active]` is not sampled in the strobe cycle itself.
- Abort while busy: `up_rdy=1` in the cycle after `up_abort`, satisfying the upstream abort contract.
- Watchdog: strobe in cycle 0, AP never ready → `dn_abort[active]` in cycle `TIMEOUT`; `up_rdy=1`, `up_err=1`, `timeout_evt=1` in cycle `TIMEOUT+1`.
- `up_rdata` holds its value until the next completion, RAZ access or watchdog event.

## Test plan
- Read with `N_APS=4`, `up_sel=2`, AP2 ready after 3 waits with rdata `0x12345678` → only `dn_ren[2]` pulses in cycle 0; `up_rdy` low cycles 1–4; cycle 5 `up_rdy=1`, `up_rdata=0x12345678`, `up_err=0`.
- Write to `up_sel=3` with AP3 asserting `dn_err` on completion → `up_err=1` for exactly one cycle, concurrent with `up_rdy` rising; sticky-error path observed upstream.
- Read with `up_sel=0x10`, `N_APS=4` → no `dn_*` strobe; next cycle `up_rdata=0`, `up_err=0`, `up_rdy` never low.
- `TIMEOUT=8`, AP1 hangs after a read → `dn_abort[1]` in cycle 8; cycle 9 `up_rdy=1`, `up_err=1`, `timeout_evt=1`, `up_rdata=0`; a new access to AP0 then completes normally.
- `up_abort` two cycles into a busy transfer, with `dn_rdy` asserted in the same cycle → all `dn_abort` bits high; next cycle `up_rdy=1`, `up_err=0`, `up_rdata` unchanged from before.
- Assert `rst` mid-transfer → next cycle `up_rdy=1`, all registered outputs 0; a subsequent access behaves as from reset.
